// File: rtl/def.sv
// Shared decode definitions: opcodes, funct fields,
// instruction flag indices and the control_info bundle.
package decode_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LB   = 3'd0;
  localparam logic [2:0] F3_LH   = 3'd1;
  localparam logic [2:0] F3_LW   = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4;
  localparam logic [2:0] F3_LHU  = 3'd5;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam int NUM_INSTR = 45;

  typedef enum logic [5:0] {
    I_LUI, I_AUIPC, I_JAL, I_JALR,
    I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
    I_LB, I_LH, I_LW, I_LBU, I_LHU,
    I_SB, I_SH, I_SW,
    I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI,
    I_SLLI, I_SRLI, I_SRAI,
    I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU,
    I_XOR, I_SRL, I_SRA, I_OR, I_AND,
    I_MUL, I_MULH, I_MULHSU, I_MULHU,
    I_DIV, I_DIVU, I_REM, I_REMU
  } instr_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef struct packed {
    logic [NUM_INSTR-1:0] flag;
    logic [4:0]           rd;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [31:0]          imm;
    logic [31:0]          pc;
  } control_info_t;

endpackage

// File: rtl/decode_stage_decode.sv
// rv32im_decode_comb: combinational RV32I/M decoder.
// In: INSTRUCTION, PC, ENABLE_M. Out: RS1, RS2, CTR_INFO, ILLEGAL.
module rv32im_decode_comb
  import decode_stage_pkg::*;
(
  input  logic [31:0]   INSTRUCTION,
  input  logic [31:0]   PC,
  input  logic          ENABLE_M,
  output logic [4:0]    RS1,
  output logic [4:0]    RS2,
  output control_info_t CTR_INFO,
  output logic          ILLEGAL
);

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        hit;
  fmt_e        fmt;
  instr_e      id;

  assign ins = INSTRUCTION;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  always_comb begin
    hit = 1'b1;
    fmt = FMT_I;
    id  = I_ADDI;
    unique case (opc)
      OP_LUI:   begin fmt = FMT_U; id = I_LUI;   end
      OP_AUIPC: begin fmt = FMT_U; id = I_AUIPC; end
      OP_JAL:   begin fmt = FMT_J; id = I_JAL;   end
      OP_JALR: begin
        id  = I_JALR;
        hit = (f3 == 3'd0);
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        unique case (f3)
          F3_BEQ:  id = I_BEQ;
          F3_BNE:  id = I_BNE;
          F3_BLT:  id = I_BLT;
          F3_BGE:  id = I_BGE;
          F3_BLTU: id = I_BLTU;
          F3_BGEU: id = I_BGEU;
          default: hit = 1'b0;
        endcase
      end
      OP_LOAD: begin
        unique case (f3)
          F3_LB:   id = I_LB;
          F3_LH:   id = I_LH;
          F3_LW:   id = I_LW;
          F3_LBU:  id = I_LBU;
          F3_LHU:  id = I_LHU;
          default: hit = 1'b0;
        endcase
      end
      OP_STORE: begin
        fmt = FMT_S;
        unique case (f3)
          3'd0:    id = I_SB;
          3'd1:    id = I_SH;
          3'd2:    id = I_SW;
          default: hit = 1'b0;
        endcase
      end
      OP_IMM: begin
        unique case (f3)
          F3_ADD:  id = I_ADDI;
          F3_SLT:  id = I_SLTI;
          F3_SLTU: id = I_SLTIU;
          F3_XOR:  id = I_XORI;
          F3_OR:   id = I_ORI;
          F3_AND:  id = I_ANDI;
          F3_SLL: begin
            id  = I_SLLI;
            hit = (f7 == F7_BASE);
          end
          F3_SR: begin
            id  = (f7 == F7_ALT) ? I_SRAI : I_SRLI;
            hit = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          default: hit = 1'b0;
        endcase
      end
      OP_REG: begin
        fmt = FMT_R;
        if (f7 == F7_BASE) begin
          unique case (f3)
            F3_ADD:  id = I_ADD;
            F3_SLL:  id = I_SLL;
            F3_SLT:  id = I_SLT;
            F3_SLTU: id = I_SLTU;
            F3_XOR:  id = I_XOR;
            F3_SR:   id = I_SRL;
            F3_OR:   id = I_OR;
            default: id = I_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          unique case (f3)
            F3_ADD:  id = I_SUB;
            F3_SR:   id = I_SRA;
            default: hit = 1'b0;
          endcase
        end else if (f7 == F7_MULDIV && ENABLE_M) begin
          // M ops are enumerated in funct3 order
          id = instr_e'(6'(I_MUL) + {3'b000, f3});
        end else begin
          hit = 1'b0;
        end
      end
      default: hit = 1'b0;
    endcase
  end

  // Illegal entries carry only the pc
  always_comb begin
    CTR_INFO    = '0;
    CTR_INFO.pc = PC;
    RS1         = '0;
    RS2         = '0;
    ILLEGAL     = ~hit;
    if (hit) begin
      CTR_INFO.flag[id] = 1'b1;
      unique case (fmt)
        FMT_R: begin
          RS1             = ins[19:15];
          RS2             = ins[24:20];
          CTR_INFO.rd     = ins[11:7];
          CTR_INFO.funct3 = f3;
          CTR_INFO.funct7 = f7;
        end
        FMT_I: begin
          RS1             = ins[19:15];
          CTR_INFO.rd     = ins[11:7];
          CTR_INFO.funct3 = f3;
          CTR_INFO.imm    = {{20{ins[31]}}, ins[31:20]};
        end
        FMT_S: begin
          RS1             = ins[19:15];
          RS2             = ins[24:20];
          CTR_INFO.funct3 = f3;
          CTR_INFO.imm    = {{20{ins[31]}}, ins[31:25],
                             ins[11:7]};
        end
        FMT_B: begin
          RS1             = ins[19:15];
          RS2             = ins[24:20];
          CTR_INFO.funct3 = f3;
          CTR_INFO.imm    = {{19{ins[31]}}, ins[31], ins[7],
                             ins[30:25], ins[11:8], 1'b0};
        end
        FMT_U: begin
          CTR_INFO.rd  = ins[11:7];
          CTR_INFO.imm = {ins[31:12], 12'b0};
        end
        FMT_J: begin
          CTR_INFO.rd  = ins[11:7];
          CTR_INFO.imm = {{11{ins[31]}}, ins[31], ins[19:12],
                          ins[20], ins[30:21], 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32IM decode feeding a QDEPTH-entry output FIFO.
// Valid/ready in and out, FLUSH, saturating illegal counter.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int QDEPTH   = 2,
  parameter bit ENABLE_M = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INSTRUCTION,
  input  logic [31:0]      PC,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [4:0]       RS1,
  output logic [4:0]       RS2,
  output control_info_t    CTR_INFO,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] ILLEGAL_COUNT
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);

  typedef struct packed {
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          ill;
    control_info_t ci;
  } entry_t;

  logic [4:0]    dec_rs1;
  logic [4:0]    dec_rs2;
  control_info_t dec_ci;
  logic          dec_ill;

  entry_t          mem_q [QDEPTH];
  entry_t          head;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic            push, pop;

  rv32im_decode_comb u_dec (
    .INSTRUCTION (INSTRUCTION),
    .PC          (PC),
    .ENABLE_M    (ENABLE_M),
    .RS1         (dec_rs1),
    .RS2         (dec_rs2),
    .CTR_INFO    (dec_ci),
    .ILLEGAL     (dec_ill)
  );

  assign OUT_VALID = (cnt_q != '0);
  assign pop       = OUT_VALID & OUT_READY;
  assign IN_READY  = ((cnt_q < FULL) | pop) & ~FLUSH & ~RST;
  assign push      = IN_VALID & IN_READY;

  // Gate the head so an empty queue reads as all zero
  assign head      = OUT_VALID ? mem_q[rptr_q] : '0;
  assign RS1       = head.rs1;
  assign RS2       = head.rs2;
  assign ILLEGAL   = head.ill;
  assign CTR_INFO  = head.ci;
  assign ILLEGAL_COUNT = icnt_q;

  always_comb begin
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    icnt_d = icnt_q;
    if (push && dec_ill && (icnt_q != '1)) begin
      icnt_d = icnt_q + CNT_W'(1);
    end
    if (FLUSH) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      icnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      icnt_q <= icnt_d;
      if (push) begin
        mem_q[wptr_q] <= '{dec_rs1, dec_rs2, dec_ill, dec_ci};
      end
    end
  end

endmodule
